aether_engine_cmd_issuer: RTL and testbench

//  Host-side command issuer driving the Aether Engine decoder's 24-bit command bus.

---
 rtl/aether_engine_cmd_issuer_if.sv | 27 ++
 rtl/aether_engine_cmd_issuer.sv | 133 +++++++++++++
 tb/tb_aether_engine_cmd_issuer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aether_engine_cmd_issuer_if.sv
// Host request, decoder command and read-response signals of the Aether Engine command issuer.
// The issuer takes the slave side; the host/decoder environment takes the master side.
interface aether_engine_cmd_issuer_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [3:0]  req_op_i;
   logic [3:0]  req_sel_i;
   logic [15:0] req_data_i;
   logic [23:0] cmd_o;
   logic        buffer_full_i;
   logic [15:0] data_i;
   logic        rsp_valid_o;
   logic [15:0] rsp_data_o;
   logic [3:0]  rsp_sel_o;
   logic        err_illegal_o;
   logic        busy_o;

   modport master (
      output req_valid_i, req_op_i, req_sel_i, req_data_i, buffer_full_i, data_i,
      input  req_ready_o, cmd_o, rsp_valid_o, rsp_data_o, rsp_sel_o, err_illegal_o, busy_o
   );

   modport slave (
      input  req_valid_i, req_op_i, req_sel_i, req_data_i, buffer_full_i, data_i,
      output req_ready_o, cmd_o, rsp_valid_o, rsp_data_o, rsp_sel_o, err_illegal_o, busy_o
   );
endinterface

// File: rtl/aether_engine_cmd_issuer.sv
// Aether Engine command issuer: queues host requests and presents each as a one-cycle
// command on the decoder bus, holding NOP otherwise and capturing READ_REG responses.
module aether_engine_cmd_issuer #(
   parameter int FifoDepth   = 4,
   parameter int ReadLatency = 1,
   parameter int BootReset   = 1
) (
   input logic                       clk_i,
   input logic                       rst_ni,
   aether_engine_cmd_issuer_if.slave bus
);
   localparam int            PtrW        = $clog2(FifoDepth);
   localparam logic [PtrW:0] FullCount   = (PtrW + 1)'(FifoDepth);
   localparam logic [3:0]    LatencyLoad = 4'(ReadLatency);
   localparam logic [23:0]   BootCmd     = 24'h100000;
   localparam logic [3:0]    OpRead      = 4'd3;
   localparam logic [3:0]    OpLast      = 4'd4;

   typedef enum logic [1:0] {BOOT, IDLE, WAIT_RSP} state_e;

   state_e          state, state_nxt;
   logic [23:0]     fifo_mem [FifoDepth];
   logic [PtrW-1:0] wr_ptr, rd_ptr;
   logic [PtrW:0]   count;
   logic [23:0]     head;
   logic            empty, full, push, pop, read_pop;
   logic [3:0]      wait_cnt, pend_sel;
   logic [23:0]     cmd_nxt;
   logic            err_nxt, rsp_capture;

   assign empty           = (count == '0);
   assign full            = (count == FullCount);
   assign push            = bus.req_valid_i & ~full;
   assign head            = fifo_mem[rd_ptr];
   assign read_pop        = pop && (head[23:20] == OpRead);
   assign bus.req_ready_o = ~full;
   assign bus.busy_o      = ~empty || (state != IDLE);

   // Request storage carries no reset; occupancy is governed by count alone.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {bus.req_op_i, bus.req_sel_i, bus.req_data_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= (BootReset != 0) ? BOOT : IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:     if (!bus.buffer_full_i) state_nxt = IDLE;
         IDLE:     if (!empty && !bus.buffer_full_i && head[23:20] == OpRead) state_nxt = WAIT_RSP;
         WAIT_RSP: if (wait_cnt == '0) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Back-pressure only matters when something would be driven; WAIT_RSP always holds NOP.
   always_comb begin
      pop         = 1'b0;
      cmd_nxt     = '0;
      err_nxt     = 1'b0;
      rsp_capture = 1'b0;
      case (state)
         BOOT: begin
            if (!bus.buffer_full_i) cmd_nxt = BootCmd;
         end
         IDLE: begin
            if (!empty && !bus.buffer_full_i) begin
               pop = 1'b1;
               if (head[23:20] <= OpLast) begin
                  cmd_nxt = head;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         WAIT_RSP: begin
            rsp_capture = (wait_cnt == '0);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus.cmd_o         <= '0;
         bus.err_illegal_o <= 1'b0;
         bus.rsp_valid_o   <= 1'b0;
         bus.rsp_data_o    <= '0;
         bus.rsp_sel_o     <= '0;
         wait_cnt          <= '0;
         pend_sel          <= '0;
      end else begin
         bus.cmd_o         <= cmd_nxt;
         bus.err_illegal_o <= err_nxt;
         bus.rsp_valid_o   <= rsp_capture;
         if (rsp_capture) begin
            bus.rsp_data_o <= bus.data_i;
            bus.rsp_sel_o  <= pend_sel;
         end
         if (read_pop) begin
            wait_cnt <= LatencyLoad;
            pend_sel <= head[19:16];
         end else if (state == WAIT_RSP && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_aether_engine_cmd_issuer.sv
// Self-checking bench for aether_engine_cmd_issuer: directed scenarios plus a randomized
// run scored against a queue-based model of request order, issue slots and read timing.
module tb_aether_engine_cmd_issuer;
   localparam int FifoDepth   = 4;
   localparam int ReadLatency = 1;
   localparam int BootReset   = 1;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   logic exp_busy_rst;

   aether_engine_cmd_issuer_if bus_if ();

   aether_engine_cmd_issuer #(
      .FifoDepth  (FifoDepth),
      .ReadLatency(ReadLatency),
      .BootReset  (BootReset)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic drive_req(input logic valid, input logic [3:0] op, input logic [3:0] sel,
                            input logic [15:0] data);
      bus_if.req_valid_i = valid;
      bus_if.req_op_i    = op;
      bus_if.req_sel_i   = sel;
      bus_if.req_data_i  = data;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (bus_if.cmd_o !== 24'h0) begin failures++; $display("[TB] FAIL reset_cmd got=%h exp=000000", bus_if.cmd_o); end
      checks++; if (bus_if.rsp_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", bus_if.rsp_valid_o); end
      checks++; if (bus_if.rsp_data_o !== 16'h0) begin failures++; $display("[TB] FAIL reset_rsp_data got=%h exp=0000", bus_if.rsp_data_o); end
      checks++; if (bus_if.rsp_sel_o !== 4'h0) begin failures++; $display("[TB] FAIL reset_rsp_sel got=%h exp=0", bus_if.rsp_sel_o); end
      checks++; if (bus_if.err_illegal_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", bus_if.err_illegal_o); end
      checks++; if (bus_if.req_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", bus_if.req_ready_o); end
      checks++; if (bus_if.busy_o !== exp_busy_rst) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=%b", bus_if.busy_o, exp_busy_rst); end
   endtask

   // Release reset under back-pressure: the boot command must wait for the decoder.
   task automatic test_boot();
      bus_if.buffer_full_i = 1'b1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (bus_if.cmd_o !== 24'h0) begin failures++; $display("[TB] FAIL boot_held_cmd got=%h exp=000000", bus_if.cmd_o); end
         checks++; if (bus_if.busy_o !== 1'b1) begin failures++; $display("[TB] FAIL boot_held_busy got=%b exp=1", bus_if.busy_o); end
      end
      bus_if.buffer_full_i = 1'b0;
      @(negedge clk);
      checks++; if (bus_if.cmd_o !== 24'h100000) begin failures++; $display("[TB] FAIL boot_cmd got=%h exp=100000", bus_if.cmd_o); end
      @(negedge clk);
      checks++; if (bus_if.cmd_o !== 24'h0) begin failures++; $display("[TB] FAIL boot_after_cmd got=%h exp=000000", bus_if.cmd_o); end
      checks++; if (bus_if.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL boot_after_busy got=%b exp=0", bus_if.busy_o); end
   endtask

   task automatic test_write();
      @(negedge clk);
      drive_req(1'b1, 4'd2, 4'd3, 16'h1234);
      @(negedge clk);
      drive_req(1'b0, 4'd0, 4'd0, 16'h0);
      checks++; if (bus_if.cmd_o !== 24'h0) begin failures++; $display("[TB] FAIL write_early got=%h exp=000000", bus_if.cmd_o); end
      @(negedge clk);
      checks++; if (bus_if.cmd_o !== 24'h231234) begin failures++; $display("[TB] FAIL write_cmd got=%h exp=231234", bus_if.cmd_o); end
      @(negedge clk);
      checks++; if (bus_if.cmd_o !== 24'h0) begin failures++; $display("[TB] FAIL write_nop got=%h exp=000000", bus_if.cmd_o); end
      checks++; if (bus_if.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL write_busy got=%b exp=0", bus_if.busy_o); end
   endtask

   // Read followed by a queued write; data_i carries BEEF only in the sampling cycle.
   task automatic test_read();
      int n_rd  = -1;
      int n_rsp = -1;
      int n_wr  = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus_if.cmd_o == 24'h370000 && n_rd < 0) n_rd = c;
         if (bus_if.cmd_o == 24'h2100AA && n_wr < 0) n_wr = c;
         if (bus_if.rsp_valid_o === 1'b1) begin
            if (n_rsp >= 0) begin
               checks++; failures++;
               $display("[TB] FAIL read_rsp_once got=second_pulse_at_%0d exp=single_pulse", c);
            end else begin
               n_rsp = c;
               checks++; if (bus_if.rsp_data_o !== 16'hBEEF) begin failures++; $display("[TB] FAIL read_rsp_data got=%h exp=beef", bus_if.rsp_data_o); end
               checks++; if (bus_if.rsp_sel_o !== 4'd7) begin failures++; $display("[TB] FAIL read_rsp_sel got=%h exp=7", bus_if.rsp_sel_o); end
            end
         end
         if (c == 0)      drive_req(1'b1, 4'd3, 4'd7, 16'h0000);
         else if (c == 1) drive_req(1'b1, 4'd2, 4'd1, 16'h00AA);
         else             drive_req(1'b0, 4'd0, 4'd0, 16'h0000);
         bus_if.data_i = (n_rd >= 0 && c == n_rd + ReadLatency) ? 16'hBEEF : 16'h0000;
      end
      checks++; if (n_rd != 2) begin failures++; $display("[TB] FAIL read_issue_cycle got=%0d exp=2", n_rd); end
      checks++; if (n_rsp != n_rd + ReadLatency + 1) begin failures++; $display("[TB] FAIL read_rsp_cycle got=%0d exp=%0d", n_rsp, n_rd + ReadLatency + 1); end
      checks++; if (n_wr != n_rsp + 1) begin failures++; $display("[TB] FAIL read_write_after_rsp got=%0d exp=%0d", n_wr, n_rsp + 1); end
   endtask

   task automatic test_back_pressure();
      logic [23:0] exp_cmds [4];
      for (int i = 0; i < 4; i++) begin
         exp_cmds[i] = {4'd2, 4'(i + 8), 16'($urandom)};
      end
      bus_if.buffer_full_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c > 0) begin
            checks++; if (bus_if.cmd_o !== 24'h0) begin failures++; $display("[TB] FAIL bp_cmd_held got=%h exp=000000", bus_if.cmd_o); end
         end
         if (c < 4) drive_req(1'b1, exp_cmds[c][23:20], exp_cmds[c][19:16], exp_cmds[c][15:0]);
      end
      checks++; if (bus_if.req_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_full got=%b exp=0", bus_if.req_ready_o); end
      checks++; if (bus_if.busy_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_busy got=%b exp=1", bus_if.busy_o); end
      drive_req(1'b1, 4'd2, 4'hF, 16'hFFFF);
      @(negedge clk);
      drive_req(1'b0, 4'd0, 4'd0, 16'h0);
      bus_if.buffer_full_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (bus_if.cmd_o !== exp_cmds[i]) begin failures++; $display("[TB] FAIL bp_issue_%0d got=%h exp=%h", i, bus_if.cmd_o, exp_cmds[i]); end
      end
      @(negedge clk);
      checks++; if (bus_if.cmd_o !== 24'h0) begin failures++; $display("[TB] FAIL bp_no_extra got=%h exp=000000", bus_if.cmd_o); end
   endtask

   task automatic test_illegal();
      int n_err = -1;
      int errs  = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus_if.err_illegal_o === 1'b1) begin
            errs++;
            n_err = c;
            checks++; if (bus_if.cmd_o !== 24'h0) begin failures++; $display("[TB] FAIL illegal_cmd_nop got=%h exp=000000", bus_if.cmd_o); end
         end
         if (n_err >= 0 && c == n_err + 1) begin
            checks++; if (bus_if.cmd_o !== 24'h420010) begin failures++; $display("[TB] FAIL illegal_next_cmd got=%h exp=420010", bus_if.cmd_o); end
         end
         if (c == 0)      drive_req(1'b1, 4'd9, 4'(c + 5), 16'($urandom));
         else if (c == 1) drive_req(1'b1, 4'd4, 4'd2, 16'h0010);
         else             drive_req(1'b0, 4'd0, 4'd0, 16'h0);
      end
      checks++; if (errs != 1 || n_err != 2) begin failures++; $display("[TB] FAIL illegal_pulse got=%0d_pulses_at_%0d exp=1_pulse_at_2", errs, n_err); end
   endtask

   task automatic test_reset_mid_read();
      int n_rd  = -1;
      int boots = 0;
      for (int c = 0; c < 10 && n_rd < 0; c++) begin
         @(negedge clk);
         if (bus_if.cmd_o[23:20] == 4'd3) n_rd = c;
         if (n_rd < 0 && c == 0)      drive_req(1'b1, 4'd3, 4'd5, 16'h0042);
         else if (n_rd < 0 && c == 1) drive_req(1'b1, 4'd2, 4'd6, 16'h5555);
         else                         drive_req(1'b0, 4'd0, 4'd0, 16'h0);
      end
      checks++; if (n_rd != 2) begin failures++; $display("[TB] FAIL rmr_read_issue got=%0d exp=2", n_rd); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus_if.cmd_o !== 24'h0) begin failures++; $display("[TB] FAIL rmr_cmd got=%h exp=000000", bus_if.cmd_o); end
      checks++; if (bus_if.rsp_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rmr_rsp_valid got=%b exp=0", bus_if.rsp_valid_o); end
      checks++; if (bus_if.req_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rmr_ready got=%b exp=1", bus_if.req_ready_o); end
      checks++; if (bus_if.busy_o !== exp_busy_rst) begin failures++; $display("[TB] FAIL rmr_busy got=%b exp=%b", bus_if.busy_o, exp_busy_rst); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus_if.cmd_o === 24'h100000) boots++;
         checks++; if (bus_if.cmd_o !== 24'h0 && bus_if.cmd_o !== 24'h100000) begin failures++; $display("[TB] FAIL rmr_stray_cmd got=%h exp=000000", bus_if.cmd_o); end
         checks++; if (bus_if.rsp_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rmr_stray_rsp got=%b exp=0", bus_if.rsp_valid_o); end
         checks++; if (bus_if.req_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rmr_ready_after got=%b exp=1", bus_if.req_ready_o); end
      end
      checks++; if (boots != ((BootReset != 0) ? 1 : 0)) begin failures++; $display("[TB] FAIL rmr_boot_count got=%0d exp=%0d", boots, (BootReset != 0) ? 1 : 0); end
   endtask

   // Model: FIFO of accepted requests; a pop happens on an edge when the previous cycle
   // had a queued request, no back-pressure and no read outstanding.
   task automatic test_random();
      logic [23:0] exp_q [$];
      logic [15:0] dhist [0:511];
      logic [23:0] head;
      logic [23:0] req;
      logic [23:0] exp_cmd;
      logic [3:0]  pend_sel   = 4'h0;
      logic [3:0]  op;
      int          pend       = -1;
      int          prev_avail = 0;
      logic        prev_bf    = 1'b0;
      logic        prev_wait  = 1'b0;
      logic        exp_pop, exp_err, exp_rsp, model_ready, model_busy, want;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         exp_pop = !prev_wait && prev_avail > 0 && !prev_bf;
         exp_cmd = 24'h0;
         exp_err = 1'b0;
         if (exp_pop) begin
            head = exp_q.pop_front();
            if (head[23:20] > 4'd4) begin
               exp_err = 1'b1;
            end else begin
               exp_cmd = head;
               if (head[23:20] == 4'd3) begin
                  pend     = t + ReadLatency + 1;
                  pend_sel = head[19:16];
               end
            end
         end
         checks++; if (bus_if.cmd_o !== exp_cmd) begin failures++; $display("[TB] FAIL rnd_cmd t=%0d got=%h exp=%h", t, bus_if.cmd_o, exp_cmd); end
         checks++; if (bus_if.err_illegal_o !== exp_err) begin failures++; $display("[TB] FAIL rnd_err t=%0d got=%b exp=%b", t, bus_if.err_illegal_o, exp_err); end
         exp_rsp = (pend == t);
         checks++; if (bus_if.rsp_valid_o !== exp_rsp) begin failures++; $display("[TB] FAIL rnd_rsp_valid t=%0d got=%b exp=%b", t, bus_if.rsp_valid_o, exp_rsp); end
         if (exp_rsp) begin
            checks++; if (bus_if.rsp_data_o !== dhist[t-1]) begin failures++; $display("[TB] FAIL rnd_rsp_data t=%0d got=%h exp=%h", t, bus_if.rsp_data_o, dhist[t-1]); end
            checks++; if (bus_if.rsp_sel_o !== pend_sel) begin failures++; $display("[TB] FAIL rnd_rsp_sel t=%0d got=%h exp=%h", t, bus_if.rsp_sel_o, pend_sel); end
            pend = -1;
         end
         model_ready = (exp_q.size() < FifoDepth);
         model_busy  = (exp_q.size() != 0) || (pend >= 0);
         checks++; if (bus_if.req_ready_o !== model_ready) begin failures++; $display("[TB] FAIL rnd_ready t=%0d got=%b exp=%b", t, bus_if.req_ready_o, model_ready); end
         checks++; if (bus_if.busy_o !== model_busy) begin failures++; $display("[TB] FAIL rnd_busy t=%0d got=%b exp=%b", t, bus_if.busy_o, model_busy); end
         prev_avail = exp_q.size();
         prev_wait  = (pend >= 0);
         want = (t < 300) && ($urandom_range(0, 2) != 0);
         op   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(1, 4));
         req  = {op, 4'($urandom), 16'($urandom)};
         drive_req(want, req[23:20], req[19:16], req[15:0]);
         if (want && model_ready) exp_q.push_back(req);
         prev_bf = (t < 300) && ($urandom_range(0, 3) == 0);
         bus_if.buffer_full_i = prev_bf;
         dhist[t] = 16'($urandom);
         bus_if.data_i = dhist[t];
      end
      drive_req(1'b0, 4'd0, 4'd0, 16'h0);
      bus_if.buffer_full_i = 1'b0;
      bus_if.data_i = 16'h0;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clk          = 1'b0;
      rst_n        = 1'b0;
      exp_busy_rst = (BootReset != 0);
      drive_req(1'b0, 4'd0, 4'd0, 16'h0);
      bus_if.buffer_full_i = 1'b0;
      bus_if.data_i        = 16'h0;
      test_reset();
      test_boot();
      test_write();
      test_read();
      test_back_pressure();
      test_illegal();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
